// File: rtl/smem_drain_pkg.sv
// rtl/smem_drain_pkg.sv - shared types and sizes for the SMEM mem-buffer drain
package smem_drain_pkg;
  localparam int ENTRY_W      = 64;
  localparam int ADDR_W       = 7;
  localparam int MEM_SIZE_MAX = 127;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    RELEASE
  } state_t;
endpackage

// File: rtl/smem_fin_fifo.sv
// rtl/smem_fin_fifo.sv - synchronous FIFO of pending finish events {read_num, mem_size}
module smem_fin_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/smem_mem_drain.sv
// rtl/smem_mem_drain.sv - drains finished reads' mem buffers onto a valid/ready stream
// Optional counters stat_entries/stat_reads are built only with SMEM_DRAIN_STATS_EN.
module smem_mem_drain
  import smem_drain_pkg::*;
#(
  parameter int READ_NUM_WIDTH = 6,
  parameter int FIN_FIFO_DEPTH = 4,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      finish_sign,
  input  logic [READ_NUM_WIDTH-1:0] finish_read_num,
  input  logic [ADDR_W-1:0]         finish_mem_size,
  output logic                      fin_full,
  output logic                      overflow,
  output logic                      rd_en,
  output logic [READ_NUM_WIDTH-1:0] rd_read_num,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [ENTRY_W-1:0]        rd_x_0,
  input  logic [ENTRY_W-1:0]        rd_x_1,
  input  logic [ENTRY_W-1:0]        rd_x_2,
  input  logic [ENTRY_W-1:0]        rd_x_info,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [READ_NUM_WIDTH-1:0] out_read_num,
  output logic [ENTRY_W-1:0]        out_x_0,
  output logic [ENTRY_W-1:0]        out_x_1,
  output logic [ENTRY_W-1:0]        out_x_2,
  output logic [ENTRY_W-1:0]        out_x_info,
  output logic                      out_last,
  output logic                      out_empty,
  output logic                      release_valid,
  output logic [READ_NUM_WIDTH-1:0] release_read_num,
  output logic [31:0]               stat_entries,
  output logic [31:0]               stat_reads
);
  localparam int FIFO_W = READ_NUM_WIDTH + ADDR_W;
  localparam int CNT_W  = $clog2(FIN_FIFO_DEPTH) + 1;

  state_t                    state, state_nxt;
  logic [READ_NUM_WIDTH-1:0] num;
  logic [ADDR_W-1:0]         size;
  logic [ADDR_W-1:0]         idx;
  logic [1:0]                lat_cnt;
  logic                      pop, capture, hs;
  logic                      fifo_full, fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic [FIFO_W-1:0]         fifo_data;
  logic [READ_NUM_WIDTH-1:0] pop_num;
  logic [ADDR_W-1:0]         pop_size;

  smem_fin_fifo #(.WIDTH(FIFO_W), .DEPTH(FIN_FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (finish_sign),
    .push_data ({finish_read_num, finish_mem_size}),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {pop_num, pop_size} = fifo_data;
  assign fin_full            = (fifo_count == CNT_W'(FIN_FIFO_DEPTH));
  assign rd_addr             = idx;
  assign rd_read_num         = num;
  assign release_read_num    = num;

  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (finish_sign && fifo_full) overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // out_last is also set for empty reads, so it alone selects RELEASE.
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    capture       = 1'b0;
    hs            = 1'b0;
    rd_en         = 1'b0;
    release_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = (pop_size == '0) ? HOLD : ISSUE;
        end
      end
      ISSUE: begin
        rd_en     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_cnt == 2'(RD_LATENCY)) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          hs        = 1'b1;
          state_nxt = out_last ? RELEASE : ISSUE;
        end
      end
      RELEASE: begin
        release_valid = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num          <= '0;
      size         <= '0;
      idx          <= '0;
      lat_cnt      <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_empty    <= 1'b0;
      out_read_num <= '0;
      out_x_0      <= '0;
      out_x_1      <= '0;
      out_x_2      <= '0;
      out_x_info   <= '0;
    end else begin
      if (pop) begin
        num  <= pop_num;
        size <= pop_size;
        idx  <= '0;
        if (pop_size == '0) begin
          out_valid    <= 1'b1;
          out_empty    <= 1'b1;
          out_last     <= 1'b1;
          out_read_num <= pop_num;
          out_x_0      <= '0;
          out_x_1      <= '0;
          out_x_2      <= '0;
          out_x_info   <= '0;
        end
      end
      if (state == ISSUE)     lat_cnt <= 2'd1;
      else if (state == WAIT) lat_cnt <= lat_cnt + 2'd1;
      if (capture) begin
        out_valid    <= 1'b1;
        out_empty    <= 1'b0;
        out_last     <= (idx == size - ADDR_W'(1));
        out_read_num <= num;
        out_x_0      <= rd_x_0;
        out_x_1      <= rd_x_1;
        out_x_2      <= rd_x_2;
        out_x_info   <= rd_x_info;
      end
      if (hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_empty <= 1'b0;
        if (!out_last) idx <= idx + ADDR_W'(1);
      end
    end
  end

`ifdef SMEM_DRAIN_STATS_EN
  logic [31:0] entries_q, reads_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
      reads_q   <= '0;
    end else begin
      if (hs && !out_empty) entries_q <= entries_q + 32'd1;
      if (release_valid)    reads_q   <= reads_q + 32'd1;
    end
  end
  assign stat_entries = entries_q;
  assign stat_reads   = reads_q;
`else
  assign stat_entries = '0;
  assign stat_reads   = '0;
`endif
endmodule

// File: tb/tb_smem_mem_drain.sv
// tb/tb_smem_mem_drain.sv - scoreboard bench for smem_mem_drain with a delayed buffer model
module tb_smem_mem_drain;
  localparam int RNW   = 6;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  typedef struct {
    logic [RNW-1:0] num;
    logic           last;
    logic           empty;
    logic [63:0]    x0, x1, x2, x3;
  } entry_t;

  logic clk = 1'b0, rst = 1'b1;
  logic finish_sign = 1'b0;
  logic [RNW-1:0] finish_read_num = '0;
  logic [6:0] finish_mem_size = '0;
  logic fin_full, overflow, rd_en, out_valid, out_last, out_empty, release_valid;
  logic out_ready = 1'b0;
  logic [RNW-1:0] rd_read_num, out_read_num, release_read_num;
  logic [6:0] rd_addr;
  logic [63:0] rd_x_0, rd_x_1, rd_x_2, rd_x_info;
  logic [63:0] out_x_0, out_x_1, out_x_2, out_x_info;
  logic [31:0] stat_entries, stat_reads;

  int cmp_cnt = 0;
  int err_cnt = 0;
  bit rand_en = 1'b0;
  entry_t exp_q[$];
  logic [12:0] rd_q[$];
  logic [RNW-1:0] rel_q[$];
  entry_t e;

  smem_mem_drain #(.READ_NUM_WIDTH(RNW), .FIN_FIFO_DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .finish_sign(finish_sign), .finish_read_num(finish_read_num),
    .finish_mem_size(finish_mem_size), .fin_full(fin_full), .overflow(overflow),
    .rd_en(rd_en), .rd_read_num(rd_read_num), .rd_addr(rd_addr),
    .rd_x_0(rd_x_0), .rd_x_1(rd_x_1), .rd_x_2(rd_x_2), .rd_x_info(rd_x_info),
    .out_valid(out_valid), .out_ready(out_ready), .out_read_num(out_read_num),
    .out_x_0(out_x_0), .out_x_1(out_x_1), .out_x_2(out_x_2), .out_x_info(out_x_info),
    .out_last(out_last), .out_empty(out_empty), .release_valid(release_valid),
    .release_read_num(release_read_num), .stat_entries(stat_entries), .stat_reads(stat_reads)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] buf_word(input logic [RNW-1:0] n, input logic [6:0] a, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {kb, 2'b00, n, 1'b0, a, 16'h5A5A, {1'b0, a} ^ 8'h3C, kb ^ 8'hF0, {2'b00, n} * 8'd3};
  endfunction

  // Buffer model: data appears LAT cycles after rd_en; addr 7F marks a non-read cycle.
  logic [RNW-1:0] pn [LAT];
  logic [6:0]     pa [LAT];
  always @(posedge clk) begin
    pn[0] <= rd_read_num;
    pa[0] <= rd_en ? rd_addr : 7'h7F;
    for (int i = 1; i < LAT; i++) begin
      pn[i] <= pn[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign rd_x_0    = buf_word(pn[LAT-1], pa[LAT-1], 0);
  assign rd_x_1    = buf_word(pn[LAT-1], pa[LAT-1], 1);
  assign rd_x_2    = buf_word(pn[LAT-1], pa[LAT-1], 2);
  assign rd_x_info = buf_word(pn[LAT-1], pa[LAT-1], 3);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    cmp_cnt++;
    err_cnt++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Drives one finish pulse; expectations are queued unless the event should be dropped.
  task automatic issue_finish(input logic [RNW-1:0] n, input logic [6:0] s, input bit drop);
    entry_t t;
    finish_sign = 1'b1;
    finish_read_num = n;
    finish_mem_size = s;
    if (!drop) begin
      if (s == 0) begin
        t.num = n; t.last = 1'b1; t.empty = 1'b1;
        t.x0 = '0; t.x1 = '0; t.x2 = '0; t.x3 = '0;
        exp_q.push_back(t);
      end else begin
        for (int i = 0; i < s; i++) begin
          t.num = n; t.last = (i == s - 1); t.empty = 1'b0;
          t.x0 = buf_word(n, 7'(i), 0); t.x1 = buf_word(n, 7'(i), 1);
          t.x2 = buf_word(n, 7'(i), 2); t.x3 = buf_word(n, 7'(i), 3);
          exp_q.push_back(t);
          rd_q.push_back({n, 7'(i)});
        end
      end
      rel_q.push_back(n);
    end
    @(posedge clk); #1;
    finish_sign = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0 || rel_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    if (!out_valid) fail_now("valid_timeout");
  endtask

  task automatic flush();
    exp_q.delete();
    rd_q.delete();
    rel_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        fail_now("out_unexpected");
      end else begin
        e = exp_q[0];
        check("out_read_num", 64'(out_read_num), 64'(e.num));
        check("out_last", 64'(out_last), 64'(e.last));
        check("out_empty", 64'(out_empty), 64'(e.empty));
        check("out_x_0", out_x_0, e.x0);
        check("out_x_1", out_x_1, e.x1);
        check("out_x_2", out_x_2, e.x2);
        check("out_x_info", out_x_info, e.x3);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rd_en) begin
      if (rd_q.size() == 0) fail_now("rd_unexpected");
      else check("rd_num_addr", 64'({rd_read_num, rd_addr}), 64'(rd_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && release_valid) begin
      if (rel_q.size() == 0) fail_now("release_unexpected");
      else check("release_read_num", 64'(release_read_num), 64'(rel_q.pop_front()));
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (rand_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rd, first_ov;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 0);
    check("reset_fin_full", 64'(fin_full), 0);
    check("reset_overflow", 64'(overflow), 0);
    check("reset_rd_en", 64'(rd_en), 0);
    check("reset_release", 64'(release_valid), 0);
    check("reset_out_x_0", out_x_0, 0);
    check("reset_stats", {stat_entries, stat_reads}, 0);

    // Basic read with latency measurement.
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue_finish(6'd5, 7'd3, 1'b0);
    first_rd = 0;
    first_ov = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rd_en && first_rd == 0) first_rd = k;
      if (out_valid && first_ov == 0) first_ov = k;
      if (first_rd != 0 && first_ov != 0) break;
    end
    check("latency_rd_en", 64'(first_rd), 2);
    check("latency_out_valid", 64'(first_ov), LAT + 3);
    @(posedge clk); #1;
    wait_drain();

    // Empty read.
    issue_finish(6'd2, 7'd0, 1'b0);
    wait_drain();

    // Fill the FIFO while the first read is stalled in HOLD.
    out_ready = 1'b0;
    issue_finish(6'd20, 7'd1, 1'b0);
    wait_valid();
    @(posedge clk); #1;
    issue_finish(6'd10, 7'd1, 1'b0);
    issue_finish(6'd11, 7'd2, 1'b0);
    issue_finish(6'd12, 7'd0, 1'b0);
    issue_finish(6'd13, 7'd1, 1'b0);
    finish_sign = 1'b1;
    finish_read_num = 6'd14;
    finish_mem_size = 7'd2;
    @(negedge clk);
    check("fin_full_after_4", 64'(fin_full), 1);
    check("overflow_before_5", 64'(overflow), 0);
    @(posedge clk); #1;
    finish_sign = 1'b0;
    @(negedge clk);
    check("overflow_after_5", 64'(overflow), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();
    check("overflow_sticky", 64'(overflow), 1);
    check("fin_full_drained", 64'(fin_full), 0);

    // Random backpressure.
    rand_en = 1'b1;
    issue_finish(6'd40, 7'd4, 1'b0);
    wait_drain();
    rand_en = 1'b0;
    out_ready = 1'b0;

    // Reset while entry 1 of 3 is held.
    issue_finish(6'd7, 7'd3, 1'b0);
    wait_valid();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    wait_valid();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    flush();
    @(negedge clk);
    check("midreset_out_valid", 64'(out_valid), 0);
    check("midreset_fin_full", 64'(fin_full), 0);
    check("midreset_overflow", 64'(overflow), 0);
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b1;
    issue_finish(6'd8, 7'd2, 1'b0);
    wait_drain();

    // Largest read after a clean reset.
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    flush();
    issue_finish(6'd33, 7'd127, 1'b0);
    wait_drain();
    repeat (2) @(negedge clk);
`ifdef SMEM_DRAIN_STATS_EN
    check("stat_entries", 64'(stat_entries), 127);
    check("stat_reads", 64'(stat_reads), 1);
`else
    check("stat_entries", 64'(stat_entries), 0);
    check("stat_reads", 64'(stat_reads), 0);
`endif
    check("final_out_valid", 64'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
